fsm_input_conditioner: RTL and testbench
========================================

// Module: fsm_input_conditioner
// PURPOSE
//   Conditions two raw asynchronous inputs (switches, external strobes) into clean single-cycle pulses.
//   Per channel: synchroniser, debounce state machine, rising-edge pulse generator.
//   Sits directly upstream of the two-input Moore controller: a_pulse drives its set input A, b_pulse its clear input B.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable synchronised samples required beyond the first; legal range >= 2
//   SYNC_STAGES      2   synchroniser flops per channel; legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width; derived, do not override
// PORTS
//   clk      in   1  clock
//   rst      in   1  reset, asynchronous, active-high
//   a_raw    in   1  raw input A, asynchronous to clk
//   b_raw    in   1  raw input B, asynchronous to clk
//   a_pulse  out  1  one-cycle pulse on debounced rising edge of A
//   b_pulse  out  1  one-cycle pulse on debounced rising edge of B
//   a_level  out  1  debounced level of A
//   b_level  out  1  debounced level of B
// BEHAVIOUR
//   Reset values: all sync flops 0, FSMs DB_LOW, counters 0, a_pulse/b_pulse/a_level/b_level 0, pending flag 0.
//   Synchroniser: SYNC_STAGES-flop shift chain per channel; s = last stage.
//   Debounce FSM per channel; cnt counts consecutive stable samples:
//     DB_LOW : s=1 -> DB_RISE, cnt<=0; else stay.
//     DB_RISE: s=0 -> DB_LOW (glitch rejected, no pulse); cnt==DEBOUNCE_CYCLES-1 -> DB_HIGH, pulse<=1; else cnt++.
//     DB_HIGH: s=0 -> DB_FALL, cnt<=0; else stay.
//     DB_FALL: s=1 -> DB_HIGH (glitch rejected); cnt==DEBOUNCE_CYCLES-1 -> DB_LOW; else cnt++. No pulse on falling edges.
//   Outputs:
//     - pulse is registered and high for exactly 1 cycle.
//     - level = 1 in DB_HIGH and DB_FALL.
//     - level rises in the same cycle as pulse.
//   Latency: raw stable high before edge 0 -> pulse high in cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 18).
//   Acceptance rule: input must be high at DEBOUNCE_CYCLES+1 consecutive sampled edges; any low sample restarts the count.
//   Pulse spacing: minimum spacing between pulses on one channel is 2*(DEBOUNCE_CYCLES+1) cycles.
//   Channels are fully independent unless PULSE_MUTEX_EN is defined.
//   Reset mid-debounce: all state discarded immediately.
//   Input high at reset release: a full debounce is performed and a rising pulse IS generated.
// CONFIGURATION
//   Macro: PULSE_MUTEX_EN
//   Defined:
//     - a_pulse and b_pulse never assert in the same cycle.
//     - On coincidence A wins; B is held in a pending flag and b_pulse asserts in the next cycle.
//     - b_level is not delayed.
//     - Pending flag is cleared by rst.
//   Undefined:
//     - Both pulses may assert in the same cycle.
//     - No pending flag is implemented.
// STRUCTURE
//   Package fsm_cond_pkg:
//     - typedef db_state_t {DB_LOW, DB_RISE, DB_HIGH, DB_FALL}, 2-bit encoding 00/01/10/11.
//     - Default constants for DEBOUNCE_CYCLES and SYNC_STAGES.
//   Sub-module debounce_channel:
//     - Contains synchroniser, FSM, counter, pulse and level flop.
//     - Instantiated twice.
//   Top level holds only the instances and the optional mutex logic.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted)
//   1. a_raw 0->1 held -> a_pulse=1 for exactly one cycle after edge 6; a_level=1 from the same cycle; b_* stay 0.
//   2. a_raw high 3 cycles then low -> no a_pulse, a_level stays 0; a subsequent clean 10-cycle high gives one pulse.
//   3. a_level=1, a_raw drops for 2 cycles then returns high -> a_level stays 1, no second a_pulse.
//   4. rst asserted mid-debounce while a_raw high -> outputs 0 asynchronously.
//      After release with a_raw still high -> a_pulse after edge 6 from release.
//   5. a_raw and b_raw rise on the same edge:
//      without PULSE_MUTEX_EN -> a_pulse and b_pulse in the same cycle;
//      with PULSE_MUTEX_EN -> a_pulse in cycle N, b_pulse in N+1.
//   6. Default parameters (16/2): 100 cycles of random 1-3-cycle glitches on both inputs -> zero pulses, levels stay 0.

Source files
------------

// File: rtl/fsm_cond_pkg.sv
// Shared types and default parameters for the two-channel input conditioner.
// Included by debounce_channel and fsm_input_conditioner.
package fsm_cond_pkg;

  typedef enum logic [1:0] {
    DB_LOW  = 2'b00,
    DB_RISE = 2'b01,
    DB_HIGH = 2'b10,
    DB_FALL = 2'b11
  } db_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: synchroniser chain, debounce FSM with stability counter,
// registered single-cycle rising pulse and debounced level.
module debounce_channel
  import fsm_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // cnt counts stable samples after the first one that left the settled state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DB_LOW;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        DB_LOW: begin
          if (s) begin
            state <= DB_RISE;
            cnt   <= '0;
          end
        end
        DB_RISE: begin
          if (!s) begin
            state <= DB_LOW;
          end else if (cnt == CNT_LAST) begin
            state <= DB_HIGH;
            pulse <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_HIGH: begin
          if (!s) begin
            state <= DB_FALL;
            cnt   <= '0;
          end
        end
        DB_FALL: begin
          if (s) begin
            state <= DB_HIGH;
          end else if (cnt == CNT_LAST) begin
            state <= DB_LOW;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= DB_LOW;
      endcase
    end
  end

endmodule

// File: rtl/fsm_input_conditioner.sv
// Two independent debounce channels feeding the Moore controller's A/B inputs.
// Optional macro PULSE_MUTEX_EN: serialises coincident pulses, A first, B one cycle later.
module fsm_input_conditioner
  import fsm_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_pulse,
  output logic b_pulse,
  output logic a_level,
  output logic b_level
);

  logic a_db_pulse;
  logic b_db_pulse;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (a_raw),
    .pulse(a_db_pulse),
    .level(a_level)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (b_raw),
    .pulse(b_db_pulse),
    .level(b_level)
  );

  assign a_pulse = a_db_pulse;

`ifdef PULSE_MUTEX_EN
  // Pulse spacing guarantees A cannot fire two cycles running, so one pending slot suffices
  logic b_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_pending <= 1'b0;
    end else begin
      b_pending <= (b_db_pulse | b_pending) & a_db_pulse;
    end
  end

  assign b_pulse = (b_db_pulse | b_pending) & ~a_db_pulse;
`else
  assign b_pulse = b_db_pulse;
`endif

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and random
// stimulus against a run-length reference model, on a 4/2 instance and a default 16/2 instance.
module tb_fsm_input_conditioner;

  localparam int DC   = 4;
  localparam int DC16 = 16;
  localparam int SS   = 2;
`ifdef PULSE_MUTEX_EN
  localparam bit MUTEX = 1'b1;
`else
  localparam bit MUTEX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_raw, b_raw, a16_raw, b16_raw;
  logic a_pulse, b_pulse, a_level, b_level;
  logic a16_pulse, b16_pulse, a16_level, b16_level;

  always #5 clk = ~clk;

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a_pulse(a_pulse),
    .b_pulse(b_pulse),
    .a_level(a_level),
    .b_level(b_level)
  );

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES(DC16),
    .SYNC_STAGES    (SS)
  ) dut16 (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a16_raw),
    .b_raw  (b16_raw),
    .a_pulse(a16_pulse),
    .b_pulse(b16_pulse),
    .a_level(a16_level),
    .b_level(b16_level)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channels 0/1 = dut a/b, 2/3 = dut16 a/b.
  // A level flips once DC+1 consecutive sampled values disagree with it.
  int dcs[4] = '{DC, DC, DC16, DC16};
  bit dly[4][SS];
  bit mlev[4];
  int mrun[4];
  bit mpul[4];
  bit mpend[2];
  bit exp_p[4];

  task automatic mdl_reset();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < SS; k++) dly[c][k] = 1'b0;
      mlev[c] = 1'b0; mrun[c] = 0; mpul[c] = 1'b0; exp_p[c] = 1'b0;
    end
    mpend[0] = 1'b0;
    mpend[1] = 1'b0;
  endtask

  task automatic mdl_step(input bit r0, input bit r1, input bit r2, input bit r3);
    bit raw[4];
    bit s;
    bit ea, eb;
    raw = '{r0, r1, r2, r3};
    for (int c = 0; c < 4; c++) begin
      s = dly[c][SS-1];
      for (int k = SS - 1; k > 0; k--) dly[c][k] = dly[c][k-1];
      dly[c][0] = raw[c];
      mpul[c] = 1'b0;
      if (s == mlev[c]) begin
        mrun[c] = 0;
      end else begin
        mrun[c]++;
        if (mrun[c] == dcs[c] + 1) begin
          mlev[c] = s;
          mrun[c] = 0;
          mpul[c] = s;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      ea = mpul[2*p];
      eb = mpul[2*p+1];
      exp_p[2*p] = ea;
      if (MUTEX) begin
        exp_p[2*p+1] = (eb | mpend[p]) & ~ea;
        mpend[p]     = (eb | mpend[p]) & ea;
      end else begin
        exp_p[2*p+1] = eb;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_step(a_raw, b_raw, a16_raw, b16_raw);
    #1;
  endtask

  task automatic mdl_check();
    chk("a_pulse vs model", a_pulse, exp_p[0]);
    chk("b_pulse vs model", b_pulse, exp_p[1]);
    chk("a_level vs model", a_level, mlev[0]);
    chk("b_level vs model", b_level, mlev[1]);
    chk("a16_pulse vs model", a16_pulse, exp_p[2]);
    chk("b16_pulse vs model", b16_pulse, exp_p[3]);
    chk("a16_level vs model", a16_level, mlev[2]);
    chk("b16_level vs model", b16_level, mlev[3]);
  endtask

  int npa = 0;

  task automatic run(input int n, input logic a, input logic b);
    a_raw = a;
    b_raw = b;
    for (int i = 0; i < n; i++) begin
      step();
      mdl_check();
      if (a_pulse) npa++;
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives
  task automatic async_rst(input string name);
    #3 rst = 1'b1;
    mdl_reset();
    #1;
    chk({name, " a_pulse"}, a_pulse, 1'b0);
    chk({name, " a_level"}, a_level, 1'b0);
    chk({name, " b_pulse"}, b_pulse, 1'b0);
    chk({name, " b_level"}, b_level, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  typedef struct {
    bit a, b, ap, al, bp, bl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int n, input bit a, input bit b, input bit ap,
                              input bit al, input bit bp, input bit bl);
    vec_t v;
    v = '{a, b, ap, al, bp, bl};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    int ca, cb, ga, gb, n16;
    bit pa, pb;

    // Vector index == clock edge counted from reset release
    add(2, 0, 0, 0, 0, 0, 0);
    add(6, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(2, 1, 0, 0, 1, 0, 0);
    add(6, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0, 0);
    if (MUTEX) begin
      add(1, 1, 1, 1, 1, 0, 1);
      add(1, 1, 1, 0, 1, 1, 1);
    end else begin
      add(1, 1, 1, 1, 1, 1, 1);
      add(1, 1, 1, 0, 1, 0, 1);
    end
    add(2, 1, 1, 0, 1, 0, 1);

    rst = 1'b0;
    a_raw = 1'b0; b_raw = 1'b0; a16_raw = 1'b0; b16_raw = 1'b0;
    mdl_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset a_pulse", a_pulse, 1'b0);
    chk("reset a_level", a_level, 1'b0);
    chk("reset b_pulse", b_pulse, 1'b0);
    chk("reset b_level", b_level, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      a_raw = tbl[i].a;
      b_raw = tbl[i].b;
      step();
      chk($sformatf("tbl[%0d] a_pulse", i), a_pulse, tbl[i].ap);
      chk($sformatf("tbl[%0d] a_level", i), a_level, tbl[i].al);
      chk($sformatf("tbl[%0d] b_pulse", i), b_pulse, tbl[i].bp);
      chk($sformatf("tbl[%0d] b_level", i), b_level, tbl[i].bl);
    end
    run(12, 0, 0);

    // Short glitch rejected, then a clean pulse
    npa = 0;
    run(3, 1, 0);
    run(10, 0, 0);
    chki("glitch gives no a_pulse", npa, 0);
    chk("glitch a_level", a_level, 1'b0);
    run(10, 1, 0);
    chki("clean high gives one a_pulse", npa, 1);
    chk("clean high a_level", a_level, 1'b1);

    // Short dropout while high is ignored
    run(2, 0, 0);
    run(10, 1, 0);
    chki("dropout gives no second a_pulse", npa, 1);
    chk("dropout a_level held", a_level, 1'b1);

    // Reset while settled high, then mid-debounce, then release with a_raw high
    async_rst("rst while high");
    run(3, 1, 0);
    async_rst("rst mid-debounce");
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("post-rst edge %0d a_pulse", k), a_pulse, k == 6);
      mdl_check();
    end
    run(12, 0, 0);

    // Default-parameter latency on the 16/2 instance
    a16_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("dut16 edge %0d a16_pulse", k), a16_pulse, k == 18);
      mdl_check();
    end
    a16_raw = 1'b0;
    run(20, 0, 0);

    // Random held levels on the 4/2 instance
    ca = 0; cb = 0;
    for (int i = 0; i < 400; i++) begin
      if (ca == 0) begin a_raw = 1'($urandom_range(0, 1)); ca = $urandom_range(1, 8); end
      if (cb == 0) begin b_raw = 1'($urandom_range(0, 1)); cb = $urandom_range(1, 8); end
      ca--; cb--;
      step();
      mdl_check();
    end
    run(12, 0, 0);

    // 1-3 cycle glitches on the 16/2 instance must never pass
    ga = 0; gb = 0; pa = 1'b0; pb = 1'b0; n16 = 0;
    for (int i = 0; i < 100; i++) begin
      if (ga == 0) begin pa = ~pa; ga = $urandom_range(1, 3); end
      if (gb == 0) begin pb = ~pb; gb = $urandom_range(1, 3); end
      ga--; gb--;
      a16_raw = pa; b16_raw = pb;
      step();
      mdl_check();
      if (a16_pulse || b16_pulse || a16_level || b16_level) n16++;
    end
    chki("dut16 glitch activity", n16, 0);
    a16_raw = 1'b0; b16_raw = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
